// File: rtl/bus_pkg.sv
// Shared definitions for the system bus DMA engine: register map, CTRL bit
// positions, FSM state encoding and the DMA window base address.
package bus_pkg;

  localparam logic [31:0] DMA_BASE = 32'hF000_0100;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_ABORT   = 3;
  localparam int CTRL_IRQEN   = 4;
  localparam int CTRL_ABORTED = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WRITE,
    ST_FINISH
  } dmaState_t;

  // Bus transfers are word-sized; the low address bits are dropped on load.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_dma_if.sv
// Bundle of the DMA's responder (CPU register window) and initiator (bus
// master) signals; slave is the DMA's view, master the system's view.
interface bus_dma_if;

  logic        sChipSelect;
  logic        sWriteEnable;
  logic [1:0]  sAddress;
  logic [31:0] sDataIn;
  logic [31:0] sDataOut;

  logic        mRequest;
  logic        mGrant;
  logic [31:0] mAddress;
  logic        mWriteEnable;
  logic [31:0] mDataOut;
  logic [31:0] mDataIn;

  modport slave (
    input  sChipSelect, sWriteEnable, sAddress, sDataIn, mGrant, mDataIn,
    output sDataOut, mRequest, mAddress, mWriteEnable, mDataOut
  );

  modport master (
    output sChipSelect, sWriteEnable, sAddress, sDataIn, mGrant, mDataIn,
    input  sDataOut, mRequest, mAddress, mWriteEnable, mDataOut
  );

endinterface

// File: rtl/bus_dma.sv
// Word-copy DMA engine: CPU-programmed register window plus a bus initiator
// that alternates read and write cycles (2 cycles per word while granted).
module bus_dma
  import bus_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  bus_dma_if.slave bus,
  output logic     irq
);

  dmaState_t            state;
  logic [31:0]          srcReg;
  logic [31:0]          dstReg;
  logic [LEN_WIDTH-1:0] lenReg;
  logic [31:0]          curSrc;
  logic [31:0]          curDst;
  logic [LEN_WIDTH-1:0] remain;
  logic                 done;
  logic                 aborted;
  logic                 irqEn;
  logic                 abortPend;

  logic        busy;
  logic        cpuWr;
  logic        cpuRd;
  logic        ctrlWr;
  logic        startReq;
  logic        clearReq;
  logic        abortReq;
  logic [31:0] rdData;

  assign busy     = (state != ST_IDLE);
  assign cpuWr    = bus.sChipSelect & bus.sWriteEnable;
  assign cpuRd    = bus.sChipSelect & ~bus.sWriteEnable;
  assign ctrlWr   = cpuWr && (bus.sAddress == REG_CTRL);
  assign startReq = ctrlWr & bus.sDataIn[CTRL_START] & ~busy;
  assign clearReq = ctrlWr & bus.sDataIn[CTRL_DONE];
  assign abortReq = ctrlWr & bus.sDataIn[CTRL_ABORT] & busy;

  always_comb begin
    rdData = '0;
    case (bus.sAddress)
      REG_SRC: rdData = srcReg;
      REG_DST: rdData = dstReg;
      REG_LEN: rdData = 32'(lenReg);
      default: begin
        rdData[CTRL_BUSY]    = busy;
        rdData[CTRL_DONE]    = done;
        rdData[CTRL_IRQEN]   = irqEn;
        rdData[CTRL_ABORTED] = aborted;
      end
    endcase
  end

  // Initiator outputs follow the state directly; a pending abort suppresses the read address.
  always_comb begin
    bus.mAddress     = '0;
    bus.mWriteEnable = 1'b0;
    bus.mDataOut     = '0;
    case (state)
      ST_READ: begin
        if (!abortPend) bus.mAddress = curSrc;
      end
      ST_WRITE: begin
        bus.mAddress     = curDst;
        bus.mWriteEnable = bus.mGrant;
        bus.mDataOut     = bus.mDataIn;
      end
      default: ;
    endcase
  end

  assign bus.mRequest = (state == ST_REQ) || (state == ST_READ) || (state == ST_WRITE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      srcReg       <= '0;
      dstReg       <= '0;
      lenReg       <= '0;
      curSrc       <= '0;
      curDst       <= '0;
      remain       <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      irqEn        <= 1'b0;
      abortPend    <= 1'b0;
      bus.sDataOut <= '0;
      irq          <= 1'b0;
    end else begin
      if (cpuRd) bus.sDataOut <= rdData;
      irq <= done & irqEn;

      if (cpuWr && !busy) begin
        case (bus.sAddress)
          REG_SRC: srcReg <= bus.sDataIn;
          REG_DST: dstReg <= bus.sDataIn;
          REG_LEN: lenReg <= bus.sDataIn[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      if (ctrlWr)   irqEn     <= bus.sDataIn[CTRL_IRQEN];
      if (clearReq) begin
        done    <= 1'b0;
        aborted <= 1'b0;
      end
      if (abortReq) abortPend <= 1'b1;

      // FSM updates come after the CPU writes so a FINISH beats a DONE clear.
      case (state)
        ST_IDLE: begin
          if (startReq) begin
            if (lenReg != '0) begin
              curSrc    <= wordAlign(srcReg);
              curDst    <= wordAlign(dstReg);
              remain    <= lenReg;
              done      <= 1'b0;
              aborted   <= 1'b0;
              abortPend <= 1'b0;
              state     <= ST_REQ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus.mGrant) state <= ST_READ;
        end
        ST_READ: begin
          if (abortPend) begin
            abortPend <= 1'b0;
            aborted   <= 1'b1;
            state     <= ST_FINISH;
          end else if (bus.mGrant) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Without grant the word is re-read, since the read data is stale by then.
          if (bus.mGrant) begin
            curSrc <= curSrc + 32'd4;
            curDst <= curDst + 32'd4;
            remain <= remain - LEN_WIDTH'(1);
            state  <= (remain == LEN_WIDTH'(1)) ? ST_FINISH : ST_READ;
          end else begin
            state <= ST_READ;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
